simd_alu_adder_result_stage: RTL
================================

// Module: simd_alu_adder_result_stage
// PURPOSE
//  Registered output stage directly downstream of the combinational SIMD adder.
//  - Captures the adder sum together with its operands, mode and signedness.
//  - Derives per-lane overflow flags and optionally saturates each lane.
//  - Decouples the adder from the consumer with a valid/ready 2-entry skid buffer.
//  - Keeps a saturating count of transfers that had at least one overflowing lane.
// PARAMETERS
//  SIMD_DATA_WIDTH             256  vector width in bits; must be a multiple of 16
//  SIMD_ADDER_DATA_MODE_WIDTH  2    width of data_mode; 0 = 8-bit lanes, 1 = 16-bit lanes, others invalid
//  OVF_CNT_WIDTH               16   width of the overflow event counter
// PORTS
//  clk           in   1         sole clock; all state updates on the rising edge
//  rst           in   1         asynchronous, active-high reset
//  in_valid      in   1         upstream presents a, b, sum, data_mode, data_signed, saturate
//  in_ready      out  1         stage can accept this cycle (registered)
//  a, b          in   SIMD_DATA_WIDTH             operands that were fed to the adder
//  sum           in   SIMD_DATA_WIDTH             wrap-around adder result for a, b
//  data_mode     in   SIMD_ADDER_DATA_MODE_WIDTH  lane size selector
//  data_signed   in   1         1 = two's complement lanes, 0 = unsigned lanes
//  saturate      in   1         1 = clamp overflowing lanes, 0 = pass the wrapped sum
//  out_valid     out  1         result, lane_ovf and out_mode are valid
//  out_ready     in   1         consumer accepts this cycle
//  result        out  SIMD_DATA_WIDTH             final vector
//  lane_ovf      out  SIMD_DATA_WIDTH/8           one flag per byte lane
//  out_mode      out  SIMD_ADDER_DATA_MODE_WIDTH  data_mode of the presented entry
//  ovf_cnt       out  OVF_CNT_WIDTH               overflow event count
//  ovf_cnt_clr   in   1         synchronous clear of ovf_cnt
// BEHAVIOUR
//  Reset:
//  - out_valid=0, in_ready=1, result=0, lane_ovf=0, out_mode=0, ovf_cnt=0, both buffer entries empty.
//  - Reset asserted mid-transfer discards all buffered data.
//  Handshake:
//  - Transfer occurs when valid & ready on the same edge.
//  - Payload must not change while valid is high and ready is low.
//  - Latency: an accepted input appears on the outputs the next cycle when the output register is empty or draining.
//  Buffer:
//  - Entries are an output register (OUT) and a skid register (SKD).
//  - in_ready = ~SKD.valid, registered.
//  - Accept while OUT is empty or out_ready=1: load OUT directly.
//  - Accept while OUT is full and out_ready=0: load SKD, so in_ready=0 next cycle.
//  - OUT drains while SKD is full: SKD moves to OUT and SKD is freed.
//  - Full throughput (1 transfer/cycle) when out_ready is held high.
//  - No entry is ever dropped or duplicated.
//  Lane rules (evaluated at acceptance and stored in the entry):
//  - Unsigned: overflow = carry out of the lane = (sum_lane < a_lane).
//  - Signed: overflow = (a_msb == b_msb) && (sum_msb != a_msb).
//  - Saturated value, unsigned: all ones.
//  - Saturated value, signed: 0x7F..F when a_msb=0, 0x80..0 when a_msb=1.
//  - saturate=1: result lane = saturated value if the lane overflowed, else sum lane.
//  - saturate=0: result lane = sum lane, always.
//  - 16-bit mode: lane i flag drives lane_ovf[2i] and lane_ovf[2i+1].
//  - Invalid data_mode: result=0, lane_ovf=0, entry still transfers, out_mode carries the raw value.
//  Counter:
//  - ovf_cnt +1 on each accepted input with any lane overflow.
//  - Saturates at all ones and does not wrap.
//  - ovf_cnt_clr has priority: when it coincides with an increment, ovf_cnt becomes 0.
// STRUCTURE
//  - Shared package simd_alu_pkg holds SIMD_DATA_WIDTH, SIMD_ADDER_DATA_MODE_WIDTH and localparams
//    MODE_8B=0, MODE_16B=1.
//  - Package also holds typedef simd_res_entry_t {result, lane_ovf, mode}, the contents of one buffer entry.
//  - One sub-module, simd_lane_sat: a parameterised single-lane (W=8/16) combinational
//    overflow and saturation unit, instantiated per lane for each mode.
//  - The top level muxes the 8-bit and 16-bit lane outputs by mode and owns the skid buffer and counter.
// TESTING
//  1. Mode 0, unsigned, sat=1, lane0 a=0xF0 b=0x20 sum=0x10
//     -> result lane0=0xFF, lane_ovf[0]=1, ovf_cnt=1.
//  2. Mode 0, signed, sat=1, lane0 a=0x70 b=0x20 (sum 0x90) -> 0x7F;
//     lane1 a=0x80 b=0xFF (sum 0x7F) -> 0x80; lane_ovf[1:0]=2'b11.
//  3. Mode 1, signed, sat=0, lane0 a=0x7FFF b=0x0001 -> result 0x8000, lane_ovf[1:0]=2'b11.
//  4. out_ready=0 for 3 cycles while in_valid=1 -> two entries held, in_ready=0.
//     Then out_ready=1 -> outputs in input order, no loss.
//  5. Continuous in_valid/out_ready=1 for 100 vectors -> 1 output/cycle, 1-cycle latency.
//  6. Counter at max and an overflowing transfer -> stays at max.
//     ovf_cnt_clr with a simultaneous overflow -> 0.
//     rst pulse mid-burst -> out_valid=0 with no clock edge.

Source files
------------

// File: rtl/simd_alu_pkg.sv
// Shared SIMD ALU definitions.
// Holds the default vector/mode widths, the lane-mode encodings and the
// buffer entry type used by the adder result stage.
package simd_alu_pkg;

    localparam int unsigned SIMD_DATA_WIDTH            = 256;
    localparam int unsigned SIMD_ADDER_DATA_MODE_WIDTH = 2;
    localparam int unsigned OVF_CNT_WIDTH              = 16;

    localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_8B  = 'd0;
    localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_16B = 'd1;

    // Contents of one skid-buffer entry: final vector, per-byte flags, raw mode.
    typedef struct packed {
        logic [SIMD_DATA_WIDTH-1:0]            result;
        logic [SIMD_DATA_WIDTH/8-1:0]          lane_ovf;
        logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] mode;
    } simd_res_entry_t;

    // True when any flag of an entry is set.
    function automatic logic entry_has_ovf(input simd_res_entry_t e);
        return |e.lane_ovf;
    endfunction

endpackage

// File: rtl/simd_alu_adder_result_stage_lane_sat.sv
// simd_lane_sat: single-lane overflow detection and saturation (combinational).
// Ports:
//   a_i, b_i     lane operands fed to the adder
//   sum_i        wrap-around lane sum
//   signed_i     1 = two's complement lane, 0 = unsigned lane
//   saturate_i   1 = clamp on overflow
//   res_o        lane result (clamped or wrapped sum)
//   ovf_o        lane overflow flag
module simd_lane_sat
    import simd_alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] sum_i,
    input  logic         signed_i,
    input  logic         saturate_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o
);

    logic         ovf;
    logic [W-1:0] sat_val;

    always_comb begin
        // Unsigned: a wrapped sum smaller than an operand means a carry out.
        // Signed: same-sign operands producing a differently signed sum.
        if (signed_i) begin
            ovf = (a_i[W-1] == b_i[W-1]) && (sum_i[W-1] != a_i[W-1]);
        end else begin
            ovf = (sum_i < a_i);
        end

        // Signed overflow direction follows the operand sign.
        if (!signed_i) begin
            sat_val = '1;
        end else if (a_i[W-1]) begin
            sat_val = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(W-1){1'b1}}};
        end

        res_o = (saturate_i && ovf) ? sat_val : sum_i;
        ovf_o = ovf;
    end

endmodule

// File: rtl/simd_alu_adder_result_stage.sv
// simd_alu_adder_result_stage: registered output stage after the SIMD adder.
// Derives per-lane overflow, optionally saturates, buffers results in a
// 2-entry skid buffer (OUT + SKD) and counts overflowing transfers.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready registered)
//   a, b, sum                adder operands and wrapped sum
//   data_mode                0 = 8-bit lanes, 1 = 16-bit lanes, else invalid
//   data_signed, saturate    lane interpretation and clamp enable
//   out_valid / out_ready    downstream handshake
//   result, lane_ovf         final vector and per-byte overflow flags
//   out_mode                 raw data_mode of the presented entry
//   ovf_cnt, ovf_cnt_clr     saturating overflow-transfer counter and its clear
module simd_alu_adder_result_stage
    import simd_alu_pkg::*;
#(
    parameter int unsigned SIMD_DATA_WIDTH            = simd_alu_pkg::SIMD_DATA_WIDTH,
    parameter int unsigned SIMD_ADDER_DATA_MODE_WIDTH = simd_alu_pkg::SIMD_ADDER_DATA_MODE_WIDTH,
    parameter int unsigned OVF_CNT_WIDTH              = simd_alu_pkg::OVF_CNT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]            a,
    input  logic [SIMD_DATA_WIDTH-1:0]            b,
    input  logic [SIMD_DATA_WIDTH-1:0]            sum,
    input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode,
    input  logic                                  data_signed,
    input  logic                                  saturate,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SIMD_DATA_WIDTH-1:0]            result,
    output logic [SIMD_DATA_WIDTH/8-1:0]          lane_ovf,
    output logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] out_mode,
    output logic [OVF_CNT_WIDTH-1:0]              ovf_cnt,
    input  logic                                  ovf_cnt_clr
);

    localparam int unsigned N8  = SIMD_DATA_WIDTH / 8;
    localparam int unsigned N16 = SIMD_DATA_WIDTH / 16;

    // ---------------- lane units, both modes evaluated in parallel ----------
    logic [SIMD_DATA_WIDTH-1:0] res8;
    logic [SIMD_DATA_WIDTH-1:0] res16;
    logic [N8-1:0]              ovf8;
    logic [N16-1:0]             ovf16;
    logic [N8-1:0]              ovf16_bytes;

    for (genvar i = 0; i < N8; i++) begin : g_l8
        simd_lane_sat #(.W(8)) u_lane (
            .a_i        (a[i*8 +: 8]),
            .b_i        (b[i*8 +: 8]),
            .sum_i      (sum[i*8 +: 8]),
            .signed_i   (data_signed),
            .saturate_i (saturate),
            .res_o      (res8[i*8 +: 8]),
            .ovf_o      (ovf8[i])
        );
    end

    for (genvar i = 0; i < N16; i++) begin : g_l16
        simd_lane_sat #(.W(16)) u_lane (
            .a_i        (a[i*16 +: 16]),
            .b_i        (b[i*16 +: 16]),
            .sum_i      (sum[i*16 +: 16]),
            .signed_i   (data_signed),
            .saturate_i (saturate),
            .res_o      (res16[i*16 +: 16]),
            .ovf_o      (ovf16[i])
        );
        // A 16-bit lane flag covers both of its byte positions.
        assign ovf16_bytes[2*i +: 2] = {2{ovf16[i]}};
    end

    simd_res_entry_t lane_entry;

    always_comb begin
        lane_entry      = '0;
        lane_entry.mode = data_mode;
        case (data_mode)
            MODE_8B: begin
                lane_entry.result   = res8;
                lane_entry.lane_ovf = ovf8;
            end
            MODE_16B: begin
                lane_entry.result   = res16;
                lane_entry.lane_ovf = ovf16_bytes;
            end
            default: ; // invalid mode: zero payload, raw mode still forwarded
        endcase
    end

    // ---------------- skid buffer and counter -------------------------------
    simd_res_entry_t          out_q, out_d;
    simd_res_entry_t          skd_q, skd_d;
    logic                     out_v_q, out_v_d;
    logic                     skd_v_q, skd_v_d;
    logic                     in_ready_q, in_ready_d;
    logic [OVF_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     accept;

    always_comb begin
        out_d   = out_q;
        out_v_d = out_v_q;
        skd_d   = skd_q;
        skd_v_d = skd_v_q;
        accept  = in_valid && in_ready_q;

        if (!out_v_q || out_ready) begin
            // OUT is free this edge. in_ready is low whenever SKD holds data,
            // so a buffered SKD entry and a new acceptance never collide.
            if (skd_v_q) begin
                out_d   = skd_q;
                out_v_d = 1'b1;
                skd_v_d = 1'b0;
            end else if (accept) begin
                out_d   = lane_entry;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (accept) begin
            skd_d   = lane_entry;
            skd_v_d = 1'b1;
        end

        in_ready_d = !skd_v_d;

        cnt_d = cnt_q;
        if (ovf_cnt_clr) begin
            cnt_d = '0;
        end else if (accept && entry_has_ovf(lane_entry) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skd_q      <= '0;
            out_v_q    <= 1'b0;
            skd_v_q    <= 1'b0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            out_q      <= out_d;
            skd_q      <= skd_d;
            out_v_q    <= out_v_d;
            skd_v_q    <= skd_v_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_v_q;
    assign result    = out_q.result;
    assign lane_ovf  = out_q.lane_ovf;
    assign out_mode  = out_q.mode;
    assign ovf_cnt   = cnt_q;

endmodule
